sprite_render: RTL and testbench

// Pixel-stream consumer of the sprite position block: takes latched sprite x/y, scale and facing

---
 rtl/sprite_render.sv | 185 ++++++++++++++++++
 tb/tb_sprite_render.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_render.sv
// Sprite pixel-stream renderer: walks the sprite ROM in step with the display beam and
// emits a colour index plus drawing flag with a fixed 3-cycle latency.
module sprite_render #(
    parameter int unsigned SPR_WIDTH  = 19,
    parameter int unsigned SPR_HEIGHT = 27,
    parameter int unsigned CORDW      = 16,
    parameter int unsigned COLRW      = 4,
    parameter int unsigned TRANSP     = 0,
    parameter int unsigned ADDRW      = 10
) (
    input  logic             i_clk_pix,
    input  logic             i_rst,
    input  logic             i_frame,
    input  logic             i_line,
    input  logic [CORDW-1:0] i_sx,
    input  logic [CORDW-1:0] i_sy,
    input  logic [CORDW-1:0] i_sprx,
    input  logic [CORDW-1:0] i_spry,
    input  logic [4:0]       i_scale_x,
    input  logic [4:0]       i_scale_y,
    input  logic             i_face_left,
    output logic [ADDRW-1:0] o_rom_addr,
    input  logic [COLRW-1:0] i_rom_data,
    output logic [COLRW-1:0] o_pix,
    output logic             o_drawing,
    output logic             o_busy
);

    localparam int unsigned CW = $clog2(SPR_WIDTH);
    localparam int unsigned RW = $clog2(SPR_HEIGHT);
    localparam int unsigned SW = 5;

    typedef enum logic [1:0] {IDLE, WAIT_POS, DRAW} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] sprx_q, sprx_d, spry_q, spry_d;
    logic [SW-1:0]    scx_q, scx_d, scy_q, scy_d;
    logic             face_q, face_d;
    logic             v_active_q, v_active_d;
    logic [RW-1:0]    row_q, row_d;
    logic [SW-1:0]    ysub_q, ysub_d;
    logic [CW-1:0]    col_q, col_d;
    logic [SW-1:0]    xsub_q, xsub_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             valid_q, valid_d, valid2_q;
    logic [COLRW-1:0] pix_q, pix_d;
    logic             drawing_q, drawing_d;
    logic             busy_q, busy_d;

    logic [SW-1:0]    scx_m1, scy_m1;
    logic [CW-1:0]    col_last;

    // Scale 0 behaves as 1; end-of-run comparisons use scale-1.
    always_comb begin
        scx_m1   = (scx_q == '0) ? '0 : scx_q - SW'(1);
        scy_m1   = (scy_d == '0) ? '0 : scy_d - SW'(1);
        col_last = face_q ? '0 : CW'(SPR_WIDTH - 1);
    end

    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sprx_q     <= '0;
            spry_q     <= '0;
            scx_q      <= '0;
            scy_q      <= '0;
            face_q     <= 1'b0;
            v_active_q <= 1'b0;
            row_q      <= '0;
            ysub_q     <= '0;
            col_q      <= '0;
            xsub_q     <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            valid2_q   <= 1'b0;
            pix_q      <= '0;
            drawing_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sprx_q     <= sprx_d;
            spry_q     <= spry_d;
            scx_q      <= scx_d;
            scy_q      <= scy_d;
            face_q     <= face_d;
            v_active_q <= v_active_d;
            row_q      <= row_d;
            ysub_q     <= ysub_d;
            col_q      <= col_d;
            xsub_q     <= xsub_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            valid2_q   <= valid_q;
            pix_q      <= pix_d;
            drawing_q  <= drawing_d;
            busy_q     <= busy_d;
        end
    end

    // Next state: frame latch first, then line evaluation, else beam-driven walk.
    always_comb begin
        state_d    = state_q;
        sprx_d     = sprx_q;
        spry_d     = spry_q;
        scx_d      = scx_q;
        scy_d      = scy_q;
        face_d     = face_q;
        v_active_d = v_active_q;
        row_d      = row_q;
        ysub_d     = ysub_q;
        col_d      = col_q;
        xsub_d     = xsub_q;

        if (i_frame) begin
            sprx_d     = i_sprx;
            spry_d     = i_spry;
            scx_d      = i_scale_x;
            scy_d      = i_scale_y;
            face_d     = i_face_left;
            v_active_d = 1'b0;
            state_d    = IDLE;
        end

        if (i_line) begin
            if (i_sy == spry_d) begin
                row_d      = '0;
                ysub_d     = '0;
                v_active_d = 1'b1;
                state_d    = WAIT_POS;
            end else if (v_active_d) begin
                if (ysub_q == scy_m1) begin
                    ysub_d = '0;
                    if (row_q == RW'(SPR_HEIGHT - 1)) begin
                        v_active_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = WAIT_POS;
                    end
                end else begin
                    ysub_d  = ysub_q + SW'(1);
                    state_d = WAIT_POS;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (!i_frame) begin
            case (state_q)
                WAIT_POS: begin
                    if (i_sx == sprx_q) begin
                        state_d = DRAW;
                        col_d   = face_q ? CW'(SPR_WIDTH - 1) : '0;
                        xsub_d  = '0;
                    end
                end
                DRAW: begin
                    if (xsub_q == scx_m1) begin
                        xsub_d = '0;
                        if (col_q == col_last) state_d = IDLE;
                        else col_d = face_q ? col_q - CW'(1) : col_q + CW'(1);
                    end else begin
                        xsub_d = xsub_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: address issue for every DRAW pixel, then colour stage two cycles later.
    always_comb begin
        valid_d   = (state_d == DRAW);
        addr_d    = addr_q;
        busy_d    = (state_d != IDLE);
        drawing_d = valid2_q && (i_rom_data != COLRW'(TRANSP));
        pix_d     = drawing_d ? i_rom_data : '0;
        if (valid_d) addr_d = ADDRW'(row_d) * ADDRW'(SPR_WIDTH) + ADDRW'(col_d);
    end

    assign o_rom_addr = addr_q;
    assign o_pix      = pix_q;
    assign o_drawing  = drawing_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_sprite_render.sv
// Scoreboard bench for sprite_render: a geometric model predicts each beam pixel, which is
// queued when driven and compared when it leaves the 3-cycle pipeline.
module tb_sprite_render;

    localparam int W = 19;
    localparam int H = 27;
    localparam int LINE_LEN = 128;
    localparam int SX0 = 96;

    logic        clk = 1'b0;
    logic        rst, frame, line, face;
    logic [15:0] sx, sy, sprx, spry;
    logic [4:0]  scale_x, scale_y;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data, pix;
    logic        drawing, busy;

    always #5 clk = ~clk;

    sprite_render dut (
        .i_clk_pix(clk), .i_rst(rst), .i_frame(frame), .i_line(line),
        .i_sx(sx), .i_sy(sy), .i_sprx(sprx), .i_spry(spry),
        .i_scale_x(scale_x), .i_scale_y(scale_y), .i_face_left(face),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_pix(pix), .o_drawing(drawing), .o_busy(busy)
    );

    // ROM contents: colour = low 4 address bits
    always_ff @(posedge clk) rom_data <= rom_addr[3:0];

    typedef struct { bit drw; int pix; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int  m_sprx, m_spry, m_scx, m_scy, m_sx0;
    bit  m_face, m_vok, m_lineok;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One beam cycle: drive, predict, clock, compare.
    task automatic step(input bit f, input bit l, input bit r, input int x, input int y);
        bit   valid;
        int   col, row, a, dy;
        exp_t e;
        frame = f; line = l; rst = r;
        sx = 16'(x); sy = 16'(y);
        valid = 1'b0;
        a = 0;
        if (r) begin
            m_sprx = 0; m_spry = 0; m_scx = 1; m_scy = 1; m_face = 1'b0;
            m_vok = 1'b0; m_lineok = 1'b0;
        end else begin
            if (f) begin
                m_sprx = $signed(sprx); m_spry = $signed(spry);
                m_scx = (scale_x == 0) ? 1 : int'(scale_x);
                m_scy = (scale_y == 0) ? 1 : int'(scale_y);
                m_face = face; m_vok = 1'b0; m_lineok = 1'b0;
            end
            if (l) begin
                dy = y - m_spry;
                if (dy == 0) m_vok = 1'b1;
                if (dy >= H * m_scy || dy < 0) m_vok = 1'b0;
                m_lineok = m_vok;
                m_sx0 = x;
            end
            valid = !l && !f && m_lineok && (m_sprx > m_sx0) &&
                    (x >= m_sprx) && (x < m_sprx + W * m_scx);
            if (valid) begin
                col = (x - m_sprx) / m_scx;
                if (m_face) col = W - 1 - col;
                row = (y - m_spry) / m_scy;
                a = row * W + col;
            end
            e.pix = valid ? (a % 16) : 0;
            e.drw = (e.pix != 0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            check("rst_drawing", int'(drawing), 0);
            check("rst_pix", int'(pix), 0);
            check("rst_busy", int'(busy), 0);
        end else begin
            if (valid) begin
                check("rom_addr", int'(rom_addr), a);
                check("busy", int'(busy), 1);
            end
            if (exp_q.size() >= 3) begin
                e = exp_q.pop_front();
                check("drawing", int'(drawing), int'(e.drw));
                check("pix", int'(pix), e.pix);
            end
        end
    endtask

    task automatic do_line(input int y, input int len, input bit with_frame);
        for (int i = 0; i < len; i++) step(with_frame && i == 0, i == 0, 1'b0, SX0 + i, y);
    endtask

    task automatic do_frame(input int y0, input int n);
        step(1'b1, 1'b0, 1'b0, 0, y0 - 1);
        for (int j = 0; j < n; j++) do_line(y0 + j, LINE_LEN, 1'b0);
    endtask

    task automatic set_sprite(input int x, input int y, input int scx, input int scy, input bit fl);
        sprx = 16'(x); spry = 16'(y); scale_x = 5'(scx); scale_y = 5'(scy); face = fl;
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; line = 1'b0; sx = '0; sy = '0;
        set_sprite(0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0, 0);
        check("rst_rom_addr", int'(rom_addr), 0);

        // Plain sprite, rows 50..76 drawn, 77/78 not
        set_sprite(100, 50, 1, 1, 1'b0);
        do_frame(48, 31);

        // Scaled 2x3
        set_sprite(100, 50, 2, 3, 1'b0);
        do_frame(48, 85);

        // Mirrored
        set_sprite(100, 50, 1, 1, 1'b1);
        do_frame(49, 29);

        // Position change only takes effect at frame; frame+line together draws row 0
        set_sprite(100, 50, 1, 1, 1'b0);
        do_frame(49, 2);
        sprx = 16'd200;
        for (int j = 51; j < 54; j++) do_line(j, LINE_LEN, 1'b0);
        do_line(50, LINE_LEN, 1'b1);
        for (int j = 51; j < 54; j++) do_line(j, LINE_LEN, 1'b0);

        // Line abort mid-draw, then reset mid-draw
        set_sprite(100, 50, 1, 1, 1'b0);
        do_frame(50, 2);
        do_line(52, 10, 1'b0);
        do_line(53, LINE_LEN, 1'b0);
        do_line(54, 10, 1'b0);
        step(1'b0, 1'b0, 1'b1, SX0 + 10, 54);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, SX0 + 11 + i, 54);
        for (int j = 55; j < 57; j++) do_line(j, LINE_LEN, 1'b0);

        // Zero scale acts as 1; sprite above the top edge never starts
        set_sprite(100, 50, 0, 0, 1'b0);
        do_frame(49, 30);
        set_sprite(100, -10, 1, 1, 1'b0);
        do_frame(0, 30);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
